// File: rtl/mismatch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : mismatch_scoreboard
// Description : Compares reference and DUT bits over a fixed sample window,
//               tracking sample/mismatch counts, first mismatch index and
//               the longest run of consecutive mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module mismatch_scoreboard #(
    parameter int CNT_W       = 16,
    parameter int MAX_SAMPLES = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             ref_bit,
    input  logic             dut_bit,
    output logic             running,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] error_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] max_err_run
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_SAMPLES);
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_sample_count;
    logic [CNT_W-1:0] r_error_count;
    logic             r_first_err_valid;
    logic [CNT_W-1:0] r_first_err_idx;
    logic [CNT_W-1:0] r_max_err_run;
    logic [CNT_W-1:0] r_cur_run;

    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_err_inc;
    logic [CNT_W-1:0] w_run_inc;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + C_ONE;
    endfunction

    assign w_cnt_inc = sat_inc(r_sample_count);
    assign w_err_inc = sat_inc(r_error_count);
    assign w_run_inc = sat_inc(r_cur_run);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_mismatch        <= 1'b0;
            r_sample_count    <= '0;
            r_error_count     <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
            r_max_err_run     <= '0;
            r_cur_run         <= '0;
        end else if (start) begin
            // Any state: open a fresh window; a coincident sample is dropped.
            r_state           <= S_RUN;
            r_mismatch        <= 1'b0;
            r_sample_count    <= '0;
            r_error_count     <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
            r_max_err_run     <= '0;
            r_cur_run         <= '0;
        end else begin
            r_mismatch <= 1'b0;
            if (r_state == S_RUN && sample_valid) begin
                r_sample_count <= w_cnt_inc;
                if (ref_bit != dut_bit) begin
                    r_error_count <= w_err_inc;
                    r_cur_run     <= w_run_inc;
                    r_mismatch    <= 1'b1;
                    if (w_run_inc > r_max_err_run) begin
                        r_max_err_run <= w_run_inc;
                    end
                    if (!r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_idx   <= r_sample_count;
                    end
                end else begin
                    r_cur_run <= '0;
                end
                if (w_cnt_inc == C_MAX) begin
                    r_state <= S_DONE;
                end
            end
        end
    end

    assign running         = (r_state == S_RUN);
    assign done            = (r_state == S_DONE);
    assign mismatch        = r_mismatch;
    assign sample_count    = r_sample_count;
    assign error_count     = r_error_count;
    assign first_err_valid = r_first_err_valid;
    assign first_err_idx   = r_first_err_idx;
    assign max_err_run     = r_max_err_run;

endmodule
`default_nettype wire

// File: tb/tb_mismatch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_mismatch_scoreboard
// Description : Directed self-checking bench for mismatch_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mismatch_scoreboard;

    localparam int CNT_W       = 16;
    localparam int MAX_SAMPLES = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sample_valid;
    logic             ref_bit;
    logic             dut_bit;
    logic             running;
    logic             done;
    logic             mismatch;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] error_count;
    logic             first_err_valid;
    logic [CNT_W-1:0] first_err_idx;
    logic [CNT_W-1:0] max_err_run;

    int n_checks = 0;
    int n_fails  = 0;

    mismatch_scoreboard #(
        .CNT_W      (CNT_W),
        .MAX_SAMPLES(MAX_SAMPLES)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .sample_valid   (sample_valid),
        .ref_bit        (ref_bit),
        .dut_bit        (dut_bit),
        .running        (running),
        .done           (done),
        .mismatch       (mismatch),
        .sample_count   (sample_count),
        .error_count    (error_count),
        .first_err_valid(first_err_valid),
        .first_err_idx  (first_err_idx),
        .max_err_run    (max_err_run)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic run, input logic dn,
                             input int cnt, input int err, input logic fv,
                             input int fi, input int mx);
        check({tag, ".running"},         32'(running),         32'(run));
        check({tag, ".done"},            32'(done),            32'(dn));
        check({tag, ".sample_count"},    32'(sample_count),    32'(cnt));
        check({tag, ".error_count"},     32'(error_count),     32'(err));
        check({tag, ".first_err_valid"}, 32'(first_err_valid), 32'(fv));
        check({tag, ".first_err_idx"},   32'(first_err_idx),   32'(fi));
        check({tag, ".max_err_run"},     32'(max_err_run),     32'(mx));
    endtask

    task automatic do_sample(input logic r, input logic d);
        sample_valid = 1'b1;
        ref_bit      = r;
        dut_bit      = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0; ref_bit = 1'b0; dut_bit = 1'b0;

        // Reset, then mismatching samples without start are ignored
        tick(); tick();
        check_all("reset", 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        check("reset.mismatch", 32'(mismatch), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_sample(1'b1, 1'b0);
            check("idle.mismatch", 32'(mismatch), 32'd0);
        end
        check_all("idle", 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);

        // Clean full window
        pulse_start();
        check_all("start", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < MAX_SAMPLES; i++) begin
            do_sample(i[0], i[0]);
            if (i == MAX_SAMPLES - 2) check_all("clean199", 1'b1, 1'b0, 199, 0, 1'b0, 0, 0);
        end
        check_all("clean", 1'b0, 1'b1, 200, 0, 1'b0, 0, 0);

        // Error pattern: mismatches at 3,4,5,8
        pulse_start();
        check_all("restart_from_done", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            logic mm;
            mm = (i == 3 || i == 4 || i == 5 || i == 8);
            do_sample(1'b1, ~mm);
            check($sformatf("pat.mismatch[%0d]", i), 32'(mismatch), 32'(mm));
        end
        tick();
        check("pat.mismatch_idle", 32'(mismatch), 32'd0);
        check_all("pat", 1'b1, 1'b0, 10, 4, 1'b1, 3, 3);

        // Run continues across a sample_valid gap
        pulse_start();
        do_sample(1'b0, 1'b1);
        do_sample(1'b0, 1'b1);
        check_all("gap_pre", 1'b1, 1'b0, 2, 2, 1'b1, 0, 2);
        for (int i = 0; i < 4; i++) tick();
        check("gap.mismatch", 32'(mismatch), 32'd0);
        do_sample(1'b1, 1'b0);
        check("gap.mismatch_post", 32'(mismatch), 32'd1);
        check_all("gap", 1'b1, 1'b0, 3, 3, 1'b1, 0, 3);

        // Restart mid-run with a coincident mismatching sample
        pulse_start();
        for (int i = 0; i < 7; i++) do_sample(1'b0, (i == 2 || i == 5));
        check_all("pre_restart", 1'b1, 1'b0, 7, 2, 1'b1, 2, 1);
        start = 1'b1; sample_valid = 1'b1; ref_bit = 1'b1; dut_bit = 1'b0;
        tick();
        start = 1'b0; sample_valid = 1'b0;
        check_all("restart", 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        check("restart.mismatch", 32'(mismatch), 32'd0);
        do_sample(1'b1, 1'b0);
        check_all("restart_first", 1'b1, 1'b0, 1, 1, 1'b1, 0, 1);

        // Fill to done, then post-done samples are ignored
        for (int i = 1; i < MAX_SAMPLES; i++) do_sample(1'b1, 1'b1);
        check_all("done2", 1'b0, 1'b1, 200, 1, 1'b1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            do_sample(1'b0, 1'b1);
            check("postdone.mismatch", 32'(mismatch), 32'd0);
        end
        check_all("postdone", 1'b0, 1'b1, 200, 1, 1'b1, 0, 1);

        // Reset mid-window wins over start and sample_valid
        pulse_start();
        for (int i = 0; i < 5; i++) do_sample(1'b1, i[0]);
        check_all("midwin", 1'b1, 1'b0, 5, 3, 1'b1, 0, 1);
        reset = 1'b1; start = 1'b1; sample_valid = 1'b1; ref_bit = 1'b1; dut_bit = 1'b0;
        tick();
        reset = 1'b0; start = 1'b0; sample_valid = 1'b0;
        check_all("midreset", 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        check("midreset.mismatch", 32'(mismatch), 32'd0);
        do_sample(1'b1, 1'b0);
        check_all("after_reset", 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
